// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares a single UART transmitter between N_REQ clients. A round-robin
// arbiter picks one requesting client, captures its byte onto the transmitter
// data input, strobes the transmitter start, then waits for the transmitter's
// frame-complete tick and reports completion back to that client. A watchdog
// aborts the grant if the transmitter never reports completion.
//
// Parameters:
//   N_REQ          number of clients (2..8)
//   DATA_SIZE      bits per character
//   TIMEOUT_CYCLES cycles allowed in WAIT before abort, 0 disables the watchdog
//
// Ports:
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   req          in   per-client request level
//   req_data     in   client i byte at [i*DATA_SIZE +: DATA_SIZE]
//   ack          out  one-hot pulse, client byte captured
//   done         out  one-hot pulse, client frame fully sent
//   err          out  one-hot pulse, client transfer aborted by watchdog
//   tx_din       out  byte presented to the transmitter
//   tx_start     out  one-cycle transmitter start strobe
//   tx_done_tick in   frame-complete pulse from the transmitter
//   busy         out  high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int          N_REQ          = 4,
    parameter int          DATA_SIZE      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DATA_SIZE-1:0] req_data,
    output logic [N_REQ-1:0]           ack,
    output logic [N_REQ-1:0]           done,
    output logic [N_REQ-1:0]           err,
    output logic [DATA_SIZE-1:0]       tx_din,
    output logic                       tx_start,
    input  logic                       tx_done_tick,
    output logic                       busy
);

    localparam int PTR_W = $clog2(N_REQ);
    // A disabled watchdog still keeps a 1-bit counter so the width is legal.
    localparam int WD_W  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = (TIMEOUT_CYCLES == 0) ? '0 : WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_RELEASE
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic [WD_W-1:0]      wdog_q, wdog_d;
    logic [DATA_SIZE-1:0] txDin_q, txDin_d;
    logic                 txStart_q, txStart_d;
    logic [N_REQ-1:0]     ack_q, ack_d;
    logic [N_REQ-1:0]     done_q, done_d;
    logic [N_REQ-1:0]     err_q, err_d;

    logic                 winValid;
    logic [PTR_W-1:0]     winIdx;
    logic [PTR_W-1:0]     candIdx;
    logic [DATA_SIZE-1:0] winData;
    logic [N_REQ-1:0]     winOh;
    logic [N_REQ-1:0]     ownerOh;

    // Round-robin search: walk from the highest offset down so the candidate
    // closest to ptr (lowest offset) is the one left standing.
    always_comb begin
        winValid = 1'b0;
        winIdx   = '0;
        candIdx  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            candIdx = PTR_W'((int'(ptr_q) + k) % N_REQ);
            if (req[candIdx]) begin
                winValid = 1'b1;
                winIdx   = candIdx;
            end
        end
    end

    // Decode the winner and the current owner into byte selects and one-hot
    // vectors using constant indices only.
    always_comb begin
        winData = '0;
        winOh   = '0;
        ownerOh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winIdx == PTR_W'(i)) begin
                winData  = req_data[i*DATA_SIZE +: DATA_SIZE];
                winOh[i] = 1'b1;
            end
            if (owner_q == PTR_W'(i)) begin
                ownerOh[i] = 1'b1;
            end
        end
    end

    // Next-state and registered-output logic. Every pulse output defaults to
    // zero so it lasts exactly one cycle; tx_din holds unless a new grant is made.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        wdog_d    = wdog_q;
        txDin_d   = txDin_q;
        txStart_d = 1'b0;
        ack_d     = '0;
        done_d    = '0;
        err_d     = '0;
        case (state_q)
            ST_IDLE: begin
                if (winValid) begin
                    owner_d   = winIdx;
                    txDin_d   = winData;
                    ack_d     = winOh;
                    txStart_d = 1'b1;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                wdog_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wdog_q != '1) begin
                    wdog_d = wdog_q + 1'b1;
                end
                // The done tick is checked first so it wins a tie with the timeout.
                if (tx_done_tick) begin
                    done_d  = ownerOh;
                    state_d = ST_RELEASE;
                end else if ((TIMEOUT_CYCLES != 0) && (wdog_q == WD_LIMIT)) begin
                    err_d   = ownerOh;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset abandons any transfer in flight without reporting it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            wdog_q    <= '0;
            txDin_q   <= '0;
            txStart_q <= 1'b0;
            ack_q     <= '0;
            done_q    <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            wdog_q    <= wdog_d;
            txDin_q   <= txDin_d;
            txStart_q <= txStart_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign ack      = ack_q;
    assign done     = done_q;
    assign err      = err_q;
    assign tx_din   = txDin_q;
    assign tx_start = txStart_q;
    assign busy     = (state_q != ST_IDLE);

endmodule
